reg_writeback_unit: RTL
=======================

# reg_writeback_unit

Write-side companion of the 8×16 register file. Collects writeback results from the ALU and memory-load paths, queues them in a small in-order FIFO, and drains one entry per cycle onto the register file write port (`reg_write_en`/`reg_write_dest`/`reg_write_data`). It also offers two combinational forwarding lookups so decode can see results that are still queued or in flight, not yet in the array.

## Interface
Parameters:
- `DATA_W`, 16: data width.
- `ADDR_W`, 3: register address width.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_wb_valid` in 1: memory-load result valid.
- `mem_wb_dest` in ADDR_W: memory-load destination register.
- `mem_wb_data` in DATA_W: memory-load result data.
- `alu_wb_valid` in 1: ALU result valid.
- `alu_wb_dest` in ADDR_W: ALU destination register.
- `alu_wb_data` in DATA_W: ALU result data.
- `wb_ready` out 1: high when ≥ 2 free FIFO slots.
- `reg_write_en` out 1: registered write strobe to the register file.
- `reg_write_dest` out ADDR_W: registered write address.
- `reg_write_data` out DATA_W: registered write data.
- `fwd_addr_1`, `fwd_addr_2` in ADDR_W: forwarding lookup addresses.
- `fwd_hit_1`, `fwd_hit_2` out 1: pending write to that address exists.
- `fwd_data_1`, `fwd_data_2` out DATA_W: youngest pending data for that address.
- `pending` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Enqueue only when `wb_ready`=1. Valids presented while `wb_ready`=0 are ignored; this is an upstream protocol violation, and state is unchanged.
- Same-cycle pushes from both sources: the mem entry is older and enqueues first, then the ALU entry.
- Dest 0 is hard-zero. Any push with dest 0 is discarded at enqueue and not counted.
- Drain: each cycle the FIFO is non-empty, the head is popped into the output stage.
  - Output stage gets `reg_write_en`=1, `reg_write_dest`/`reg_write_data` = head contents.
  - If the FIFO is empty, `reg_write_en`=0. Dest and data hold their last value.
- Push and pop in the same cycle are legal. Occupancy changes by +pushes−pop.
- Forwarding candidates: every valid FIFO entry plus the output stage while `reg_write_en`=1. The output stage holds the oldest candidate.
  - `fwd_hit_n`=1 if any candidate dest equals `fwd_addr_n` and `fwd_addr_n`≠0.
  - `fwd_data_n` = data of the youngest matching candidate.
  - With no hit, `fwd_data_n`=0.
- Pointers are ADDR of log2(DEPTH) bits and wrap modulo DEPTH. Occupancy never exceeds DEPTH.

## Timing
- Reset values: `reg_write_en`=0, `reg_write_dest`=0, `reg_write_data`=0, `pending`=0, `wb_ready`=1, `fwd_hit_n`=0, `fwd_data_n`=0. All FIFO entries are invalidated.
- Reset asserted mid-drain drops all queued entries immediately. No further writes are issued.
- Latency into an empty FIFO:
  - Push sampled at edge N.
  - `reg_write_en`=1 during the cycle after edge N+1.
  - Register file captures the write at edge N+2.
- Two same-cycle pushes appear on the write port on consecutive cycles: mem first, then ALU.
- `wb_ready`, `pending`, and the forwarding outputs are functions of current registered state (plus `fwd_addr_n` for the forwarding outputs). They have no combinational path from the `*_wb_valid` inputs.
- Throughput: one register write per cycle sustained.

## Configuration
- `WB_FORWARD_EN` defined: forwarding logic is built as described above.
- `WB_FORWARD_EN` undefined: `fwd_hit_1`, `fwd_hit_2`, `fwd_data_1`, `fwd_data_2` are tied to 0. No comparators are built. Queueing and drain behaviour is identical.

## Test plan
- ALU push dest 3, data 0x1234 into an idle unit:
  - `fwd_hit` for address 3 is 1 with 0x1234 for two cycles.
  - `reg_write_en` pulses once with dest 3, data 0x1234, two edges after the push.
- Same-cycle mem (dest 5, 0xAAAA) and ALU (dest 5, 0x5555) pushes:
  - Writes issue 0xAAAA then 0x5555 on consecutive cycles.
  - `fwd_data` for address 5 is 0x5555 until drained.
- Push dest 0, data 0xFFFF: `pending` stays 0, no `reg_write_en`, `fwd_hit` for address 0 is 0.
- Hold drain-visible occupancy at 3 with DEPTH=4: `wb_ready`=0. A push attempted then is ignored and `pending` is unchanged.
- Queue 3 entries, then assert `rst` asynchronously mid-drain: all outputs are 0 at once and no further write strobes appear.
- Build without `WB_FORWARD_EN` and repeat test 1: `fwd_hit`/`fwd_data` stay 0, and the write port sequence is identical.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit
// Write-side companion of the 8x16 register file. ALU and memory-load
// results are queued in a small in-order FIFO and drained one per cycle onto
// a registered register-file write port. Two combinational lookups expose
// results that are queued or sitting in the output stage.
//
// Build option: define WB_FORWARD_EN to build the forwarding comparators.
// Without it, fwd_hit_1/2 and fwd_data_1/2 are tied to zero.
module reg_writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       mem_wb_valid,
    input  logic [ADDR_W-1:0]          mem_wb_dest,
    input  logic [DATA_W-1:0]          mem_wb_data,

    input  logic                       alu_wb_valid,
    input  logic [ADDR_W-1:0]          alu_wb_dest,
    input  logic [DATA_W-1:0]          alu_wb_data,

    output logic                       wb_ready,

    output logic                       reg_write_en,
    output logic [ADDR_W-1:0]          reg_write_dest,
    output logic [DATA_W-1:0]          reg_write_data,

    input  logic [ADDR_W-1:0]          fwd_addr_1,
    input  logic [ADDR_W-1:0]          fwd_addr_2,
    output logic                       fwd_hit_1,
    output logic                       fwd_hit_2,
    output logic [DATA_W-1:0]          fwd_data_1,
    output logic [DATA_W-1:0]          fwd_data_2,

    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; entries are meaningful only within the occupied window
    // starting at rd_ptr, so they need no reset of their own.
    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              mem_take;
    logic              alu_take;
    logic              pop;
    logic [PTR_W-1:0]  alu_ptr;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_next;

    // Two free slots are required so that a dual push can never overflow,
    // regardless of whether the drain pops this cycle.
    assign wb_ready = (count <= CNT_W'(DEPTH - 2));
    assign pending  = count;

    // Accept pushes only while ready; dest 0 is the hard-zero register and is
    // dropped here so it never occupies a slot or shows up on forwarding.
    always_comb begin
        mem_take    = wb_ready && mem_wb_valid && (mem_wb_dest != '0);
        alu_take    = wb_ready && alu_wb_valid && (alu_wb_dest != '0);
        pop         = (count != '0);
        // The mem entry is older, so it takes the first free slot.
        alu_ptr     = wr_ptr + PTR_W'(mem_take);
        wr_ptr_next = wr_ptr + PTR_W'(mem_take) + PTR_W'(alu_take);
        rd_ptr_next = rd_ptr + PTR_W'(pop);
        count_next  = count + CNT_W'(mem_take) + CNT_W'(alu_take) - CNT_W'(pop);
    end

    // Write accepted entries into the FIFO storage array.
    always_ff @(posedge clk) begin
        if (mem_take) begin
            dest_mem[wr_ptr] <= mem_wb_dest;
            data_mem[wr_ptr] <= mem_wb_data;
        end
        if (alu_take) begin
            dest_mem[alu_ptr] <= alu_wb_dest;
            data_mem[alu_ptr] <= alu_wb_data;
        end
    end

    // Pointer/occupancy bookkeeping and the registered write-port stage;
    // reset empties the queue and silences the write port immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            reg_write_en <= pop;
            // Dest and data hold their last value when nothing drains.
            if (pop) begin
                reg_write_dest <= dest_mem[rd_ptr];
                reg_write_data <= data_mem[rd_ptr];
            end
        end
    end

`ifdef WB_FORWARD_EN
    logic [ADDR_W-1:0] lookup_addr [2];
    assign lookup_addr[0] = fwd_addr_1;
    assign lookup_addr[1] = fwd_addr_2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  idx;

        // Scan candidates oldest to youngest (output stage, then FIFO from
        // head) so the last match seen is the youngest one.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            idx  = '0;
            if (reg_write_en && (reg_write_dest == lookup_addr[gi])) begin
                hit  = 1'b1;
                data = reg_write_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PTR_W'(k);
                if ((CNT_W'(k) < count) && (dest_mem[idx] == lookup_addr[gi])) begin
                    hit  = 1'b1;
                    data = data_mem[idx];
                end
            end
            // Register 0 always reads as zero, never as a pending write.
            if (lookup_addr[gi] == '0) begin
                hit  = 1'b0;
                data = '0;
            end
        end
    end

    assign fwd_hit_1  = g_lookup[0].hit;
    assign fwd_data_1 = g_lookup[0].data;
    assign fwd_hit_2  = g_lookup[1].hit;
    assign fwd_data_2 = g_lookup[1].data;
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{fwd_addr_1, fwd_addr_2};

    assign fwd_hit_1  = 1'b0;
    assign fwd_data_1 = '0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_2 = '0;
`endif

endmodule
